// File: rtl/sa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sa_pkg
// Purpose  : Shared states and array dimensions for the systolic-array sequencer.
// Revision : 1.0
// ============================================================================
package sa_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam int ROW_NUM_DEF     = 4;
    localparam int BUFFER_SIZE_DEF = 4;

    localparam int FEED_CYC  = BUFFER_SIZE_DEF + ROW_NUM_DEF - 1;
    localparam int DRAIN_CYC = 2 * ROW_NUM_DEF - 1;

    // Lets parameterised instances derive the same phase lengths.
    function automatic int feed_cyc(input int rows, input int bsz);
        return bsz + rows - 1;
    endfunction

    function automatic int drain_cyc(input int rows);
        return 2 * rows - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sa_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : sa_sequencer_if
// Purpose  : Word-pair load handshake plus buffer/PE steering for the sequencer.
// Revision : 1.0
// ============================================================================
interface sa_sequencer_if
    import sa_pkg::*;
#(
    parameter int ROW_NUM = ROW_NUM_DEF
);
    logic               start;
    logic               data_valid;
    logic               read_data;
    logic [ROW_NUM-1:0] in_valid_A;
    logic [ROW_NUM-1:0] in_valid_B;
    logic [ROW_NUM-1:0] mux_select;
    logic               pe_clear;
    logic               busy;
    logic               done;

    modport master (
        output start, data_valid,
        input  read_data, in_valid_A, in_valid_B, mux_select, pe_clear, busy, done
    );

    modport slave (
        input  start, data_valid,
        output read_data, in_valid_A, in_valid_B, mux_select, pe_clear, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/sa_skew_gen.sv
`default_nettype none
// ============================================================================
// Module   : sa_skew_gen
// Purpose  : Registered diagonal skew decode of feed step t into mux_select.
// Revision : 1.0
// ============================================================================
module sa_skew_gen
    import sa_pkg::*;
#(
    parameter int ROW_NUM     = ROW_NUM_DEF,
    parameter int BUFFER_SIZE = BUFFER_SIZE_DEF,
    parameter int T_W         = 4
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               en,
    input  wire logic [T_W-1:0]     t,
    output logic      [ROW_NUM-1:0] mux_select
);
    logic [ROW_NUM-1:0] mux_select_d;
    logic [ROW_NUM-1:0] mux_select_q;

    // Row r sees its buffer during steps r .. r+BUFFER_SIZE-1.
    for (genvar r = 0; r < ROW_NUM; r++) begin : g_row
        always_comb begin
            mux_select_d[r] = en && (32'(t) >= r) && (32'(t) < r + BUFFER_SIZE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_select_q <= '0;
        end else begin
            mux_select_q <= mux_select_d;
        end
    end

    assign mux_select = mux_select_q;

endmodule
`default_nettype wire

// File: rtl/sa_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sa_sequencer
// Purpose  : Load / skewed feed / drain controller for the 4x4 systolic array.
// Revision : 1.0
// ============================================================================
module sa_sequencer
    import sa_pkg::*;
#(
    parameter int ROW_NUM     = ROW_NUM_DEF,
    parameter int BUFFER_SIZE = BUFFER_SIZE_DEF,
    parameter int CNT_W       = $clog2(ROW_NUM * BUFFER_SIZE + 1)
) (
    input wire logic         clk,
    input wire logic         rst_n,
    sa_sequencer_if.slave    bus
);
    localparam int TOTAL   = ROW_NUM * BUFFER_SIZE;
    localparam int N_FEED  = feed_cyc(ROW_NUM, BUFFER_SIZE);
    localparam int N_DRAIN = drain_cyc(ROW_NUM);
    localparam int PH_MAX  = (N_FEED > N_DRAIN) ? N_FEED : N_DRAIN;
    localparam int PH_W    = $clog2(PH_MAX + 1);
    localparam int RW      = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
    localparam int COL_W   = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;

    state_e             state_d,    state_q;
    logic [CNT_W-1:0]   word_cnt_d, word_cnt_q;
    logic [RW-1:0]      row_cnt_d,  row_cnt_q;
    logic [COL_W-1:0]   col_cnt_d,  col_cnt_q;
    logic [PH_W-1:0]    ph_cnt_d,   ph_cnt_q;
    logic               pe_clear_d, pe_clear_q;
    logic               accept_w;
    logic               feed_en_w;
    logic [ROW_NUM-1:0] strobe_w;

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        row_cnt_d  = row_cnt_q;
        col_cnt_d  = col_cnt_q;
        ph_cnt_d   = ph_cnt_q;
        pe_clear_d = 1'b0;
        accept_w   = 1'b0;
        feed_en_w  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = LOAD;
                    pe_clear_d = 1'b1;
                    word_cnt_d = '0;
                    row_cnt_d  = '0;
                    col_cnt_d  = '0;
                    ph_cnt_d   = '0;
                end
            end
            LOAD: begin
                accept_w = bus.data_valid;
                if (accept_w) begin
                    word_cnt_d = word_cnt_q + CNT_W'(1);
                    if (col_cnt_q == COL_W'(BUFFER_SIZE - 1)) begin
                        col_cnt_d = '0;
                        row_cnt_d = row_cnt_q + RW'(1);
                    end else begin
                        col_cnt_d = col_cnt_q + COL_W'(1);
                    end
                    if (word_cnt_q == CNT_W'(TOTAL - 1)) begin
                        state_d   = FEED;
                        ph_cnt_d  = '0;
                        feed_en_w = 1'b1;
                    end
                end
            end
            FEED: begin
                // feed_en_w/ph_cnt_d describe the next cycle so the skew register lines up.
                if (ph_cnt_q == PH_W'(N_FEED - 1)) begin
                    state_d  = DRAIN;
                    ph_cnt_d = '0;
                end else begin
                    ph_cnt_d  = ph_cnt_q + PH_W'(1);
                    feed_en_w = 1'b1;
                end
            end
            DRAIN: begin
                if (ph_cnt_q == PH_W'(N_DRAIN - 1)) begin
                    state_d  = DONE;
                    ph_cnt_d = '0;
                end else begin
                    ph_cnt_d = ph_cnt_q + PH_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        strobe_w = '0;
        for (int r = 0; r < ROW_NUM; r++) begin
            strobe_w[r] = accept_w && (row_cnt_q == RW'(r));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            row_cnt_q  <= '0;
            col_cnt_q  <= '0;
            ph_cnt_q   <= '0;
            pe_clear_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            row_cnt_q  <= row_cnt_d;
            col_cnt_q  <= col_cnt_d;
            ph_cnt_q   <= ph_cnt_d;
            pe_clear_q <= pe_clear_d;
        end
    end

    sa_skew_gen #(
        .ROW_NUM     (ROW_NUM),
        .BUFFER_SIZE (BUFFER_SIZE),
        .T_W         (PH_W)
    ) u_skew (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (feed_en_w),
        .t          (ph_cnt_d),
        .mux_select (bus.mux_select)
    );

    assign bus.read_data  = (state_q == LOAD);
    assign bus.in_valid_A = strobe_w;
    assign bus.in_valid_B = strobe_w;
    assign bus.pe_clear   = pe_clear_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);

endmodule
`default_nettype wire

// File: doc/sa_sequencer.md
# sa_sequencer

Sequencing controller for the 4x4 weight/activation systolic array. It accepts a paired A/B word stream and steers each word pair into the correct per-row A and B buffers. It then issues the diagonally skewed feed enables that push buffer contents into the PE grid, waits for the array to drain, and signals completion. It sits beside the row buffers and PE array at top level and replaces the ad-hoc load/feed control.

## Interface
Parameters:
- ROW_NUM, 4, rows (= columns) of the PE array; number of A buffers and of B buffers
- BUFFER_SIZE, 4, words per row buffer
- CNT_W, $clog2(ROW_NUM*BUFFER_SIZE+1), width of internal word/cycle counters

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  begin one matrix job; sampled in IDLE only
- data_valid  in  1  A/B word pair present on the shared data buses
- read_data  out  1  sequencer accepts a word pair this cycle
- in_valid_A  out  ROW_NUM  one-hot write strobe to A row buffer r
- in_valid_B  out  ROW_NUM  one-hot write strobe to B row buffer r
- mux_select  out  ROW_NUM  bit r=1: row/column r buffer output drives the PE edge; 0: drive zero
- pe_clear  out  1  one-cycle clear of all PE accumulators
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when the job's results are final

## Operation
- States: IDLE, LOAD, FEED, DRAIN, DONE.
- IDLE: start=1 -> LOAD. start outside IDLE is ignored.
- LOAD:
  - read_data=1.
  - Accept = data_valid & read_data.
  - in_valid_A[r] = in_valid_B[r] = accept & (row_cnt==r). This is combinational from registered state/row_cnt plus data_valid.
  - word_cnt increments on accept. Row_cnt advances after every BUFFER_SIZE accepts.
  - On accept number ROW_NUM*BUFFER_SIZE -> FEED.
  - data_valid low stalls the load with no penalty.
- FEED:
  - Feed counter t runs 0..BUFFER_SIZE+ROW_NUM-2.
  - mux_select[r]=1 iff r <= t < r+BUFFER_SIZE (diagonal skew).
  - After the last t -> DRAIN.
- DRAIN: mux_select=0 for DRAIN_CYC = 2*ROW_NUM-1 cycles, then -> DONE.
- DONE: done=1 for one cycle, then -> IDLE.
- pe_clear=1 only in the first LOAD cycle.
- data_valid outside LOAD: ignored; no strobes, read_data=0.
- All registered outputs reset to 0; state resets to IDLE; all counters reset to 0.
- rst_n low mid-job aborts immediately. Partial buffer contents are don't-care. The next job starts with a fresh pe_clear.

## Timing
- Latency from start sampled at edge 0, with data_valid held high:
  - LOAD: cycles 1..16; pe_clear in cycle 1.
  - FEED: cycles 17..23.
  - DRAIN: cycles 24..30.
  - done: cycle 31.
  - IDLE: cycle 32.
- A new start may be sampled in cycle 32 at the earliest.
- FEED and DRAIN lengths are fixed and independent of data_valid.
- mux_select pattern over the 7 FEED cycles (bit3..bit0): 0001, 0011, 0111, 1111, 1110, 1100, 1000.
- busy rises the cycle after start is sampled and falls in the cycle after done.
- With data_valid=1 in the 16th LOAD accept cycle, FEED begins on the next cycle.

## Structure
- Shared package sa_pkg holds:
  - state enum (IDLE, LOAD, FEED, DRAIN, DONE)
  - default ROW_NUM, BUFFER_SIZE
  - derived constants FEED_CYC = BUFFER_SIZE+ROW_NUM-1 and DRAIN_CYC = 2*ROW_NUM-1
- One sub-module: sa_skew_gen. It is a registered decode of feed counter t into mux_select, parameterised by ROW_NUM and BUFFER_SIZE.
- All state, word/row counters and strobe logic live in sa_sequencer.

## Test plan
- Reset values: hold rst_n=0 -> all outputs 0. Release, idle 5 cycles -> outputs stay 0 and busy=0.
- Back-to-back job:
  - Stimulus: start at edge 0, data_valid constant 1.
  - Strobes: in_valid_A/B = 0001 for LOAD cycles 1-4, 0010 for 5-8, 0100 for 9-12, 1000 for 13-16.
  - mux_select sequence in cycles 17-23 as listed in Timing.
  - done only in cycle 31.
- Stalled load: data_valid toggles 1/0 every cycle.
  - Exactly 16 strobes, each one-hot and row-correct.
  - FEED starts one cycle after the 16th accept.
  - No strobe on data_valid=0 cycles.
- Ignored inputs:
  - start pulsed during LOAD/FEED/DRAIN -> no state change.
  - data_valid=1 in IDLE/FEED -> in_valid_A/B stay 0 and read_data stays 0.
- Mid-job reset:
  - rst_n low in FEED cycle 20 -> all outputs 0 asynchronously.
  - A new job after release reproduces the back-to-back timing exactly, including pe_clear.
